// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: issues one SD command over the SD SPI peripheral's
// register port (select, 6-byte command, R1 poll, optional 512-byte block
// receive through the DMA path, deselect) from a single start pulse.
// Optional feature macro: SD_SEQ_CRC7_EN (serial CRC7 over command bytes 0-4;
// when undefined the CRC byte is fixed per command index).
module sd_cmd_sequencer #(
   parameter int unsigned R1_POLL_MAX    = 8,
   parameter int unsigned TOKEN_POLL_MAX = 4096
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [5:0]  i_cmd_index,
   input  logic [31:0] i_cmd_arg,
   input  logic        i_read_block,
   output logic        o_busy,
   output logic        o_done,
   output logic [1:0]  o_error,
   output logic [7:0]  o_r1,
   output logic        o_sd_request,
   output logic        o_sd_write,
   output logic [7:0]  o_sd_address,
   output logic [31:0] o_sd_data,
   input  logic        i_sd_ack,
   input  logic [31:0] i_sd_data
);

   localparam logic [7:0] A_CS    = 8'd1;
   localparam logic [7:0] A_DR    = 8'd2;
   localparam logic [7:0] A_MULTI = 8'd3;
   localparam logic [7:0] A_DMA   = 8'd4;

   localparam int unsigned    R1W       = $clog2(R1_POLL_MAX + 1);
   localparam logic [R1W-1:0] R1_MAX_C  = R1W'(R1_POLL_MAX);
   localparam logic [12:0]    TOK_MAX_C = 13'(TOKEN_POLL_MAX);

   typedef enum logic [3:0] {
      ST_IDLE, ST_SEL, ST_CMD, ST_R1, ST_TOK, ST_DMA, ST_MULTI, ST_CRC,
      ST_CSHI, ST_TRAIL, ST_GUARD1, ST_GUARD2, ST_RDREQ, ST_RDWAIT
   } state_t;

   // Which step a poll belongs to, so the shared guard/read states know where to resume.
   typedef enum logic [2:0] {
      PH_CMD, PH_R1, PH_TOK, PH_DATA, PH_CRC, PH_TRAIL
   } phase_t;

   state_t           state_q, state_d;
   phase_t           phase_q, phase_d;
   logic [2:0]       byte_cnt_q, byte_cnt_d;
   logic [R1W-1:0]   r1_cnt_q, r1_cnt_d, r1_inc;
   logic [12:0]      tok_cnt_q, tok_cnt_d, tok_inc;
   logic [5:0]       idx_q, idx_d;
   logic [31:0]      arg_q, arg_d;
   logic             rb_q, rb_d;
   logic [1:0]       error_q, error_d;
   logic [7:0]       r1_q, r1_d;
   logic             done_q, done_d;
   logic [7:0]       cmd_byte, crc_byte, rx;
   logic             rx_busy, crc_idle;
   logic             unused_sd_data;

   assign rx             = i_sd_data[7:0];
   assign rx_busy        = i_sd_data[8];
   assign unused_sd_data = ^i_sd_data[31:9];

   assign r1_inc  = (r1_cnt_q == '1) ? r1_cnt_q : r1_cnt_q + R1W'(1);
   assign tok_inc = (tok_cnt_q == '1) ? tok_cnt_q : tok_cnt_q + 13'd1;

`ifdef SD_SEQ_CRC7_EN
   logic [6:0] crc_q, crc_d;
   logic [7:0] crc_sh_q, crc_sh_d;
   logic [3:0] crc_bits_q, crc_bits_d;

   // The CRC shifts one bit per cycle behind the bytes already written; the
   // command write stalls until the previous byte has been absorbed.
   assign crc_idle = (crc_bits_q == 4'd0);
   assign crc_byte = {crc_q, 1'b1};
`else
   assign crc_idle = 1'b1;
   assign crc_byte = (idx_q == 6'd0) ? 8'h95 : (idx_q == 6'd8) ? 8'h87 : 8'h01;
`endif

   // Select the command byte currently due on the wire.
   always_comb begin
      case (byte_cnt_q)
         3'd0:    cmd_byte = {2'b01, idx_q};
         3'd1:    cmd_byte = arg_q[31:24];
         3'd2:    cmd_byte = arg_q[23:16];
         3'd3:    cmd_byte = arg_q[15:8];
         3'd4:    cmd_byte = arg_q[7:0];
         default: cmd_byte = crc_byte;
      endcase
   end

   // Next-state and bus-access decode; every bus access lasts exactly one state.
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      byte_cnt_d   = byte_cnt_q;
      r1_cnt_d     = r1_cnt_q;
      tok_cnt_d    = tok_cnt_q;
      idx_d        = idx_q;
      arg_d        = arg_q;
      rb_d         = rb_q;
      error_d      = error_q;
      r1_d         = r1_q;
      done_d       = 1'b0;
      o_sd_request = 1'b0;
      o_sd_write   = 1'b0;
      o_sd_address = '0;
      o_sd_data    = '0;
`ifdef SD_SEQ_CRC7_EN
      crc_d      = crc_q;
      crc_sh_d   = crc_sh_q;
      crc_bits_d = crc_bits_q;
      if (crc_bits_q != 4'd0) begin
         crc_d      = {crc_q[5:0], 1'b0} ^ ((crc_sh_q[7] ^ crc_q[6]) ? 7'h09 : 7'h00);
         crc_sh_d   = {crc_sh_q[6:0], 1'b0};
         crc_bits_d = crc_bits_q - 4'd1;
      end
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               idx_d      = i_cmd_index;
               arg_d      = i_cmd_arg;
               rb_d       = i_read_block;
               error_d    = 2'd0;
               byte_cnt_d = 3'd0;
               r1_cnt_d   = '0;
               tok_cnt_d  = '0;
`ifdef SD_SEQ_CRC7_EN
               crc_d      = '0;
`endif
               state_d    = ST_SEL;
            end
         end
         ST_SEL: begin
            o_sd_request = 1'b1;
            o_sd_write   = 1'b1;
            o_sd_address = A_CS;
            state_d      = ST_CMD;
         end
         ST_CMD: begin
            if (crc_idle) begin
               o_sd_request = 1'b1;
               o_sd_write   = 1'b1;
               o_sd_address = A_DR;
               o_sd_data    = {24'd0, cmd_byte};
`ifdef SD_SEQ_CRC7_EN
               if (byte_cnt_q != 3'd5) begin
                  crc_sh_d   = cmd_byte;
                  crc_bits_d = 4'd8;
               end
`endif
               phase_d      = PH_CMD;
               state_d      = ST_GUARD1;
            end
         end
         ST_R1, ST_TOK, ST_TRAIL: begin
            o_sd_request = 1'b1;
            o_sd_write   = 1'b1;
            o_sd_address = A_DR;
            o_sd_data    = 32'h0000_00FF;
            phase_d      = (state_q == ST_R1)  ? PH_R1 :
                           (state_q == ST_TOK) ? PH_TOK : PH_TRAIL;
            state_d      = ST_GUARD1;
         end
         ST_DMA: begin
            o_sd_request = 1'b1;
            o_sd_write   = 1'b1;
            o_sd_address = A_DMA;
            o_sd_data    = 32'h0000_0003;
            state_d      = ST_MULTI;
         end
         ST_MULTI, ST_CRC: begin
            o_sd_request = 1'b1;
            o_sd_write   = 1'b1;
            o_sd_address = A_MULTI;
            o_sd_data    = (state_q == ST_MULTI) ? 32'h0000_07FF : 32'h0000_0201;
            phase_d      = (state_q == ST_MULTI) ? PH_DATA : PH_CRC;
            state_d      = ST_GUARD1;
         end
         ST_CSHI: begin
            o_sd_request = 1'b1;
            o_sd_write   = 1'b1;
            o_sd_address = A_CS;
            o_sd_data    = 32'h0000_0001;
            state_d      = ST_TRAIL;
         end
         ST_GUARD1: state_d = ST_GUARD2;
         ST_GUARD2: state_d = ST_RDREQ;
         ST_RDREQ: begin
            o_sd_request = 1'b1;
            o_sd_address = A_DR;
            state_d      = ST_RDWAIT;
         end
         ST_RDWAIT: begin
            if (i_sd_ack && rx_busy) begin
               state_d = ST_RDREQ;
            end else if (i_sd_ack) begin
               case (phase_q)
                  PH_CMD: begin
                     if (byte_cnt_q == 3'd5) begin
                        state_d = ST_R1;
                     end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        state_d    = ST_CMD;
                     end
                  end
                  PH_R1: begin
                     if (!rx[7]) begin
                        r1_d    = rx;
                        state_d = (rb_q && rx == 8'h00) ? ST_TOK : ST_CSHI;
                     end else begin
                        r1_cnt_d = r1_inc;
                        if (r1_inc == R1_MAX_C) begin
                           error_d = 2'd1;
                           state_d = ST_CSHI;
                        end else begin
                           state_d = ST_R1;
                        end
                     end
                  end
                  PH_TOK: begin
                     if (rx == 8'hFE) begin
                        state_d = ST_DMA;
                     end else if (rx[7:5] == 3'b000) begin
                        error_d = 2'd3;
                        state_d = ST_CSHI;
                     end else begin
                        tok_cnt_d = tok_inc;
                        if (tok_inc == TOK_MAX_C) begin
                           error_d = 2'd2;
                           state_d = ST_CSHI;
                        end else begin
                           state_d = ST_TOK;
                        end
                     end
                  end
                  PH_DATA: state_d = ST_CRC;
                  PH_CRC:  state_d = ST_CSHI;
                  PH_TRAIL: begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
                  default: state_d = ST_CSHI;
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and result registers; reset drops straight back to idle.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         phase_q    <= PH_CMD;
         byte_cnt_q <= '0;
         r1_cnt_q   <= '0;
         tok_cnt_q  <= '0;
         idx_q      <= '0;
         arg_q      <= '0;
         rb_q       <= 1'b0;
         error_q    <= 2'd0;
         r1_q       <= 8'hFF;
         done_q     <= 1'b0;
`ifdef SD_SEQ_CRC7_EN
         crc_q      <= '0;
         crc_sh_q   <= '0;
         crc_bits_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         byte_cnt_q <= byte_cnt_d;
         r1_cnt_q   <= r1_cnt_d;
         tok_cnt_q  <= tok_cnt_d;
         idx_q      <= idx_d;
         arg_q      <= arg_d;
         rb_q       <= rb_d;
         error_q    <= error_d;
         r1_q       <= r1_d;
         done_q     <= done_d;
`ifdef SD_SEQ_CRC7_EN
         crc_q      <= crc_d;
         crc_sh_q   <= crc_sh_d;
         crc_bits_q <= crc_bits_d;
`endif
      end
   end

   assign o_busy  = (state_q != ST_IDLE);
   assign o_done  = done_q;
   assign o_error = error_q;
   assign o_r1    = r1_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: a card/peripheral model answers bus traffic,
// and a transaction-level model predicts the exact list of register writes
// and the final result of each command.
`timescale 1ns/1ps
module tb_sd_cmd_sequencer;

   localparam int unsigned R1MAX = 8;
   localparam int unsigned TMAX  = 4096;
   localparam logic [7:0]  A_CS = 8'd1, A_DR = 8'd2, A_MULTI = 8'd3, A_DMA = 8'd4;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_start = 1'b0;
   logic [5:0]  i_cmd_index = '0;
   logic [31:0] i_cmd_arg = '0;
   logic        i_read_block = 1'b0;
   logic        o_busy, o_done, o_sd_request, o_sd_write;
   logic [1:0]  o_error;
   logic [7:0]  o_r1, o_sd_address;
   logic [31:0] o_sd_data;
   logic        i_sd_ack = 1'b0;
   logic [31:0] i_sd_data = '0;

   sd_cmd_sequencer #(.R1_POLL_MAX(R1MAX), .TOKEN_POLL_MAX(TMAX)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
      .i_cmd_index(i_cmd_index), .i_cmd_arg(i_cmd_arg), .i_read_block(i_read_block),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_r1(o_r1),
      .o_sd_request(o_sd_request), .o_sd_write(o_sd_write),
      .o_sd_address(o_sd_address), .o_sd_data(o_sd_data),
      .i_sd_ack(i_sd_ack), .i_sd_data(i_sd_data)
   );

   always #5 i_clk = ~i_clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [39:0] exp_q[$];
   logic [7:0]  resp_q[$];
   logic [1:0]  exp_err = 2'd0;
   logic [7:0]  exp_r1 = 8'hFF;
   logic        exp_busy = 1'b0;
   int          done_cnt = 0;
   int          d0_g = 0;
   logic        saw_dma = 1'b0;
   int          dr_wr_n = 0;
   logic [47:0] cmd_log = '0;
   int          busy_max = 3;
   int          mcyc = 0;
   int          last_gw = -100;
   logic        rd_out = 1'b0;
   logic        p_req, p_wr;
   logic [7:0]  p_addr;
   int          p_bcnt = 0;
   logic [7:0]  p_rxb = 8'hFF;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // CRC7 as the remainder of (message * x^7) divided by x^7+x^3+1.
   function automatic logic [6:0] crc7(input logic [39:0] m);
      logic [46:0] r;
      r = {m, 7'd0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] head;
      logic [7:0]  crc;
      head = {2'b01, idx, arg};
`ifdef SD_SEQ_CRC7_EN
      crc = {crc7(head), 1'b1};
`else
      crc = (idx == 6'd0) ? 8'h95 : (idx == 6'd8) ? 8'h87 : 8'h01;
      if (crc7(head) == 7'h7F) crc = crc;
`endif
      return {head, crc};
   endfunction

   // Card/peripheral: reads are acknowledged one cycle later; each DR write
   // delivers the next scripted card byte after a random busy time.
   initial begin : periph
      forever begin
         @(negedge i_clk);
         p_req = o_sd_request; p_wr = o_sd_write; p_addr = o_sd_address;
         @(posedge i_clk); #1;
         i_sd_ack = 1'b0;
         if (i_reset) begin
            p_bcnt = 0; p_rxb = 8'hFF;
         end else begin
            if (p_bcnt > 0) p_bcnt--;
            if (p_req && !p_wr) begin
               i_sd_ack  = 1'b1;
               i_sd_data = {23'd0, (p_bcnt != 0), p_rxb};
            end else if (p_req && p_addr == A_DR) begin
               p_rxb  = (resp_q.size() != 0) ? resp_q.pop_front() : 8'hFF;
               p_bcnt = $urandom_range(0, busy_max);
            end else if (p_req && p_addr == A_MULTI) begin
               p_rxb  = 8'hFF;
               p_bcnt = $urandom_range(4, 4 + 4 * busy_max);
            end
         end
      end
   end

   // Single compare process: bus writes against the predicted list, read
   // protocol rules, busy level every cycle and the result at done.
   initial begin : monitor
      forever begin
         @(negedge i_clk);
         mcyc++;
         if (i_reset) begin
            rd_out  = 1'b0;
            last_gw = -100;
         end else begin
            if (o_sd_request) check("req_while_read_pending", rd_out, 0);
            if (o_sd_request && o_sd_write) begin
               if (o_sd_address == A_DR || o_sd_address == A_MULTI) last_gw = mcyc;
               if (o_sd_address == A_DMA) saw_dma = 1'b1;
               if (o_sd_address == A_DR && dr_wr_n < 6) begin
                  cmd_log = {cmd_log[39:0], o_sd_data[7:0]};
                  dr_wr_n++;
               end
               if (exp_q.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL extra_write: got addr %0h data %0h, expected none", o_sd_address, o_sd_data);
               end else begin
                  check("bus_write", {o_sd_address, o_sd_data}, exp_q.pop_front());
               end
            end else if (o_sd_request) begin
               check("read_addr", o_sd_address, A_DR);
               check("read_guard", (mcyc - last_gw) >= 3, 1);
               rd_out = 1'b1;
            end
            if (i_sd_ack) rd_out = 1'b0;
            if (o_done) begin
               check("done_when_active", exp_busy, 1);
               check("busy_at_done", o_busy, 0);
               check("error", o_error, exp_err);
               check("r1", o_r1, exp_r1);
               check("writes_left", exp_q.size(), 0);
               exp_busy = 1'b0;
               done_cnt++;
            end else begin
               check("busy", o_busy, exp_busy);
            end
         end
      end
   end

   // Predict the write list and result for one command from the card script.
   task automatic prep_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic rb,
                           input int nff, input logic [7:0] r1v, input int tff, input logic [7:0] tok);
      logic [47:0] fr;
      int np;
      fr = cmd_frame(idx, arg);
      exp_q.delete(); resp_q.delete();
      exp_err = 2'd0;
      exp_q.push_back({A_CS, 32'd0});
      for (int k = 0; k < 6; k++) begin
         exp_q.push_back({A_DR, 24'd0, fr[47-8*k -: 8]});
         resp_q.push_back(8'hFF);
      end
      np = (nff >= int'(R1MAX)) ? int'(R1MAX) : nff + 1;
      for (int p = 0; p < np; p++) begin
         exp_q.push_back({A_DR, 32'h0000_00FF});
         resp_q.push_back((p < nff) ? (8'h80 | 8'($urandom_range(0, 127))) : r1v);
      end
      if (nff >= int'(R1MAX)) begin
         exp_err = 2'd1;
      end else begin
         exp_r1 = r1v;
         if (rb && r1v == 8'h00) begin
            np = (tff >= int'(TMAX)) ? int'(TMAX) : tff + 1;
            for (int p = 0; p < np; p++) begin
               exp_q.push_back({A_DR, 32'h0000_00FF});
               resp_q.push_back((p < tff) ? (($urandom_range(0, 1) == 1) ? 8'hFF : (8'h20 | 8'($urandom_range(0, 31)))) : tok);
            end
            if (tff >= int'(TMAX)) exp_err = 2'd2;
            else if (tok == 8'hFE) begin
               exp_q.push_back({A_DMA, 32'h0000_0003});
               exp_q.push_back({A_MULTI, 32'h0000_07FF});
               exp_q.push_back({A_MULTI, 32'h0000_0201});
            end else exp_err = 2'd3;
         end
      end
      exp_q.push_back({A_CS, 32'h0000_0001});
      exp_q.push_back({A_DR, 32'h0000_00FF});
   endtask

   task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic rb);
      d0_g = done_cnt; dr_wr_n = 0; saw_dma = 1'b0;
      @(negedge i_clk);
      i_start = 1'b1; i_cmd_index = idx; i_cmd_arg = arg; i_read_block = rb;
      @(posedge i_clk); #1;
      i_start = 1'b0; exp_busy = 1'b1;
      // scramble inputs to show they were latched
      i_cmd_index = 6'($urandom); i_cmd_arg = $urandom; i_read_block = 1'($urandom);
   endtask

   task automatic wait_done(input int budget);
      for (int c = 0; c < budget && done_cnt == d0_g; c++) @(posedge i_clk);
      if (done_cnt == d0_g) begin
         vectors++; miscompares++;
         $display("FAIL done_timeout: got no done within %0d cycles, expected done", budget);
      end
      @(posedge i_clk);
   endtask

   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic rb,
                          input int nff, input logic [7:0] r1v, input int tff, input logic [7:0] tok,
                          input int budget);
      prep_cmd(idx, arg, rb, nff, r1v, tff, tok);
      start_cmd(idx, arg, rb);
      wait_done(budget);
   endtask

   task automatic check_reset_values();
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_error", o_error, 0);
      check("rst_r1", o_r1, 8'hFF);
      check("rst_req", o_sd_request, 0);
      check("rst_write", o_sd_write, 0);
      check("rst_addr", o_sd_address, 0);
      check("rst_data", o_sd_data, 0);
   endtask

   initial begin : stim
      logic rb;
      int   nff, tff;
      logic [7:0] r1v, tok;
      #23;
      check_reset_values();
      @(negedge i_clk); i_reset = 1'b0;
      repeat (2) @(posedge i_clk);

      // CMD0: R1 0x01 on the second poll
      run_cmd(6'd0, 32'd0, 1'b0, 1, 8'h01, 0, 8'hFE, 4000);
      check("cmd0_bytes", cmd_log, 48'h40_0000_0000_95);
      check("cmd0_r1", o_r1, 8'h01);
      check("cmd0_err", o_error, 2'd0);

      // CMD17 block read, token after 10 polls
      run_cmd(6'd17, 32'h0000_0800, 1'b1, 0, 8'h00, 10, 8'hFE, 6000);
      check("cmd17_err", o_error, 2'd0);
      check("cmd17_r1", o_r1, 8'h00);

      // card never answers R1
      run_cmd(6'd55, 32'd0, 1'b0, 30, 8'h00, 0, 8'hFE, 4000);
      check("r1_timeout_err", o_error, 2'd1);

      // data error token
      run_cmd(6'd17, 32'h1234_5678, 1'b1, 2, 8'h00, 3, 8'h08, 4000);
      check("data_err_token", o_error, 2'd3);

      // second start mid-sequence ignored, then reset during DATA
      prep_cmd(6'd17, 32'h0000_1000, 1'b1, 0, 8'h00, 5, 8'hFE);
      start_cmd(6'd17, 32'h0000_1000, 1'b1);
      repeat (10) @(posedge i_clk);
      @(negedge i_clk); i_start = 1'b1; i_cmd_index = 6'd5; i_cmd_arg = 32'hDEAD_BEEF; i_read_block = 1'b0;
      @(posedge i_clk); #1 i_start = 1'b0;
      for (int c = 0; c < 4000 && !saw_dma; c++) @(negedge i_clk);
      check("reached_data", saw_dma, 1);
      #2;
      i_reset = 1'b1;
      exp_q.delete(); resp_q.delete(); exp_busy = 1'b0; exp_r1 = 8'hFF;
      #1;
      check_reset_values();
      repeat (3) @(negedge i_clk);
      i_reset = 1'b0;

      // CMD8 after reset; fixed and computed CRC agree on 0x87
      run_cmd(6'd8, 32'h0000_01AA, 1'b0, 0, 8'h01, 0, 8'hFE, 4000);
      check("cmd8_bytes", cmd_log, 48'h48_0000_01AA_87);
      run_cmd(6'd17, 32'd0, 1'b0, 0, 8'h05, 0, 8'hFE, 4000);
`ifdef SD_SEQ_CRC7_EN
      check("cmd17_crc7_bytes", cmd_log, 48'h51_0000_0000_55);
`else
      check("cmd17_fixed_bytes", cmd_log, 48'h51_0000_0000_01);
`endif

      // token never arrives
      busy_max = 0;
      run_cmd(6'd17, 32'h0000_0200, 1'b1, 0, 8'h00, TMAX + 5, 8'hFE, 60000);
      check("token_timeout_err", o_error, 2'd2);

      // randomized commands
      for (int n = 0; n < 25; n++) begin
         busy_max = $urandom_range(0, 5);
         rb  = 1'($urandom);
         nff = $urandom_range(0, 9);
         r1v = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(1, 127));
         tff = $urandom_range(0, 12);
         tok = ($urandom_range(0, 2) != 0) ? 8'hFE : 8'($urandom_range(0, 31));
         run_cmd(6'($urandom), $urandom, rb, nff, r1v, tff, tok, 6000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
